// File: rtl/pin_keypad_entry_if.sv
// Signal bundle between the parking controller (master) and the keypad entry block (slave).
// Strobe semantics: key_valid qualifies key_code for exactly one cycle and there is no ready;
// the slave always samples the strobe and either accepts or ignores the key. pin_valid is a
// one-cycle pulse qualifying pin, again with no back-pressure.
interface pin_keypad_entry_if;
  logic       ent_pin;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] pin;
  logic       pin_valid;
  logic       busy;
  logic       timeout;
  logic [1:0] digit_cnt;
  logic [2:0] dbg_state;

  modport master (
    output ent_pin, key_valid, key_code,
    input  pin, pin_valid, busy, timeout, digit_cnt, dbg_state
  );

  modport slave (
    input  ent_pin, key_valid, key_code,
    output pin, pin_valid, busy, timeout, digit_cnt, dbg_state
  );
endinterface

// File: rtl/pin_keypad_entry.sv
// Two-digit BCD PIN collector with CLEAR/ENTER keys, abort on ent_pin drop and an
// inactivity timeout. Every output is registered; the FSM state is exported for debug.
module pin_keypad_entry #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 16
) (
  input logic              clock,
  input logic              reset,
  pin_keypad_entry_if.slave kp
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DIG1     = 3'd1,
    S_DIG2     = 3'd2,
    S_WAIT_ENT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_n;
  logic               ent_pin_q;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [3:0]         buf_hi, buf_hi_n, buf_lo, buf_lo_n;
  logic [7:0]         pin_r, pin_n;
  logic               pin_valid_r, pin_valid_n;
  logic               timeout_r, timeout_n;
  logic               busy_r, busy_n;
  logic [1:0]         cnt_r, cnt_n;
  logic               accepted;

  logic is_digit, is_clear, is_enter, session_start;
  assign is_digit      = kp.key_valid && (kp.key_code <= 4'd9);
  assign is_clear      = kp.key_valid && (kp.key_code == 4'hC);
  assign is_enter      = kp.key_valid && (kp.key_code == 4'hE);
  // Only a fresh rising edge of ent_pin opens a session, so a held request cannot re-arm.
  assign session_start = kp.ent_pin && !ent_pin_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ent_pin_q   <= 1'b0;
      timer       <= '0;
      buf_hi      <= 4'h0;
      buf_lo      <= 4'h0;
      pin_r       <= 8'h00;
      pin_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      busy_r      <= 1'b0;
      cnt_r       <= 2'd0;
    end else begin
      state       <= state_n;
      ent_pin_q   <= kp.ent_pin;
      timer       <= timer_n;
      buf_hi      <= buf_hi_n;
      buf_lo      <= buf_lo_n;
      pin_r       <= pin_n;
      pin_valid_r <= pin_valid_n;
      timeout_r   <= timeout_n;
      busy_r      <= busy_n;
      cnt_r       <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    buf_hi_n    = buf_hi;
    buf_lo_n    = buf_lo;
    pin_n       = pin_r;
    pin_valid_n = 1'b0;
    timeout_n   = 1'b0;
    accepted    = 1'b0;
    busy_n      = 1'b0;
    cnt_n       = 2'd0;

    case (state)
      S_IDLE: begin
        if (session_start) begin
          state_n  = S_DIG1;
          timer_n  = RELOAD;
          buf_hi_n = 4'h0;
          buf_lo_n = 4'h0;
        end
      end
      S_DIG1, S_DIG2, S_WAIT_ENT: begin
        if (!kp.ent_pin) begin
          // Abort outranks any key and the timer in the same cycle.
          state_n  = S_IDLE;
          buf_hi_n = 4'h0;
          buf_lo_n = 4'h0;
        end else begin
          case (state)
            S_DIG1: begin
              if (is_digit) begin
                buf_hi_n = kp.key_code;
                state_n  = S_DIG2;
                accepted = 1'b1;
              end else if (is_clear) begin
                buf_hi_n = 4'h0;
                buf_lo_n = 4'h0;
                accepted = 1'b1;
              end
            end
            S_DIG2: begin
              if (is_digit) begin
                buf_lo_n = kp.key_code;
                state_n  = S_WAIT_ENT;
                accepted = 1'b1;
              end else if (is_clear) begin
                buf_hi_n = 4'h0;
                buf_lo_n = 4'h0;
                state_n  = S_DIG1;
                accepted = 1'b1;
              end
            end
            S_WAIT_ENT: begin
              if (is_enter) begin
                pin_n       = {buf_hi, buf_lo};
                pin_valid_n = 1'b1;
                state_n     = S_DONE;
                accepted    = 1'b1;
              end else if (is_clear) begin
                buf_hi_n = 4'h0;
                buf_lo_n = 4'h0;
                state_n  = S_DIG1;
                accepted = 1'b1;
              end
            end
            default: ;
          endcase

          // An accepted key in the expiry cycle wins over the timeout.
          if (accepted) begin
            timer_n = RELOAD;
          end else if (timer == '0) begin
            state_n   = S_IDLE;
            timeout_n = 1'b1;
            buf_hi_n  = 4'h0;
            buf_lo_n  = 4'h0;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_DIG1:     busy_n = 1'b1;
      S_DIG2:     begin busy_n = 1'b1; cnt_n = 2'd1; end
      S_WAIT_ENT: begin busy_n = 1'b1; cnt_n = 2'd2; end
      S_DONE:     cnt_n = 2'd2;
      default:    ;
    endcase
  end

  assign kp.pin       = pin_r;
  assign kp.pin_valid = pin_valid_r;
  assign kp.timeout   = timeout_r;
  assign kp.busy      = busy_r;
  assign kp.digit_cnt = cnt_r;
  assign kp.dbg_state = state;

endmodule
